// File: rtl/mem_sum_pkg.sv
// ============================================================================
//  Module   : mem_sum_pkg
//  Brief    : Shared constants and FSM state encoding for mem_sum_engine.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_sum_pkg;

    // Default widths for the engine parameters
    localparam int c_ADDR_W = 13;
    localparam int c_DATA_W = 8;
    localparam int c_CNT_W  = 8;

    // Explicitly sized, explicitly valued state encoding
    localparam int c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WR_LO = 3'd2,
        S_WR_HI = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage : mem_sum_pkg

`default_nettype wire

// File: rtl/mem_sum_engine.sv
// ============================================================================
//  Module   : mem_sum_engine
//  Brief    : Reads 'count' bytes starting at 'baseAddr' from an external
//             combinational-read memory, accumulates them into a 2*DATA_W
//             sum and (optionally) writes the sum back little-endian at
//             dstAddr / dstAddr+1.
//  Config   : define MEM_SUM_WRITEBACK_EN to enable the WR_LO/WR_HI
//             write-back states; without it the engine only computes 'sum'
//             and never drives a memory write.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_sum_engine
    import mem_sum_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int CNT_W  = c_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   baseAddr,
    input  logic [CNT_W-1:0]    count,
    input  logic [ADDR_W-1:0]   dstAddr,
    output logic [ADDR_W-1:0]   memAddress,
    input  logic [DATA_W-1:0]   memRdData,
    output logic [DATA_W-1:0]   memWrData,
    output logic                memWriteEn,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] sum
);

    localparam int SUM_W = 2 * DATA_W;

    // State that follows the last READ cycle (or IDLE when count is zero)
`ifdef MEM_SUM_WRITEBACK_EN
    localparam state_t c_AFTER_READ = S_WR_LO;
`else
    localparam state_t c_AFTER_READ = S_DONE;
`endif

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]    r_rem;
    logic [ADDR_W-1:0]   r_dst;
    logic [SUM_W-1:0]    r_sum;

    // State register; reset forces IDLE immediately so write strobes drop at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so DONE and busy states ignore it
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (count == '0) ? c_AFTER_READ : S_READ;
                end
            end
            S_READ: begin
                // r_rem still holds the bytes left including this cycle's byte
                if (r_rem == CNT_W'(1)) begin
                    w_next_state = c_AFTER_READ;
                end
            end
            S_WR_LO: w_next_state = S_WR_HI;
            S_WR_HI: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: latch the request in IDLE, accumulate one byte per READ cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            r_rem <= '0;
            r_dst <= '0;
            r_sum <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ptr <= baseAddr;
                        r_rem <= count;
                        r_dst <= dstAddr;
                        r_sum <= '0;
                    end
                end
                S_READ: begin
                    // Pointer and sum wrap naturally at their register widths
                    r_sum <= r_sum + {{(SUM_W-DATA_W){1'b0}}, memRdData};
                    r_ptr <= r_ptr + ADDR_W'(1);
                    r_rem <= r_rem - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Memory-port outputs decoded from the current state only
    always_comb begin
        memAddress = '0;
        memWrData  = '0;
        memWriteEn = 1'b0;
        case (r_state)
            S_READ: begin
                memAddress = r_ptr;
            end
`ifdef MEM_SUM_WRITEBACK_EN
            S_WR_LO: begin
                memAddress = r_dst;
                memWrData  = r_sum[DATA_W-1:0];
                memWriteEn = 1'b1;
            end
            S_WR_HI: begin
                memAddress = r_dst + ADDR_W'(1);
                memWrData  = r_sum[SUM_W-1:DATA_W];
                memWriteEn = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

`ifndef MEM_SUM_WRITEBACK_EN
    // Destination is latched but has no consumer when write-back is disabled
    logic w_unused_dst;
    assign w_unused_dst = ^r_dst;
`endif

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;

endmodule : mem_sum_engine

`default_nettype wire

// File: tb/tb_mem_sum_engine.sv
// ============================================================================
//  Module   : tb_mem_sum_engine
//  Brief    : Self-checking bench for mem_sum_engine with a behavioural
//             memory and reference sum model. Honours MEM_SUM_WRITEBACK_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_sum_engine;

    localparam int MEM_N = 8192;
`ifdef MEM_SUM_WRITEBACK_EN
    localparam int LAT_EXTRA = 3;
`else
    localparam int LAT_EXTRA = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [12:0] baseAddr = '0;
    logic [7:0]  count = '0;
    logic [12:0] dstAddr = '0;
    logic [12:0] memAddress;
    logic [7:0]  memRdData;
    logic [7:0]  memWrData;
    logic        memWriteEn;
    logic        busy;
    logic        done;
    logic [15:0] sum;

    logic [7:0]  mem     [0:MEM_N-1];
    logic [7:0]  ref_mem [0:MEM_N-1];
    logic        pl_we = 1'b0;
    logic [12:0] pl_a = '0;
    logic [7:0]  pl_d = '0;
    logic [12:0] addr_q [$];

    int checks = 0;
    int failures = 0;

    mem_sum_engine dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .baseAddr   (baseAddr),
        .count      (count),
        .dstAddr    (dstAddr),
        .memAddress (memAddress),
        .memRdData  (memRdData),
        .memWrData  (memWrData),
        .memWriteEn (memWriteEn),
        .busy       (busy),
        .done       (done),
        .sum        (sum)
    );

    always #5 clk = ~clk;

    // External memory: combinational read, write on rising edge
    assign memRdData = mem[memAddress];
    always @(posedge clk) begin
        if (pl_we) mem[pl_a] <= pl_d;
        else if (memWriteEn) mem[memAddress] <= memWrData;
    end

    // Reference: plain sum of the bytes, modulo 2^16
    function automatic logic [15:0] model_sum(input logic [12:0] b, input int c);
        int unsigned s = 0;
        for (int i = 0; i < c; i++) s += ref_mem[(int'(b) + i) % MEM_N];
        return s[15:0];
    endfunction

    // Reference: expected memory effect of the write-back
    function automatic void model_writeback(input logic [12:0] d, input logic [15:0] s);
`ifdef MEM_SUM_WRITEBACK_EN
        ref_mem[d] = s[7:0];
        ref_mem[(int'(d) + 1) % MEM_N] = s[15:8];
`else
        if (d == 13'h1FFF && s == 16'hFFFF) ref_mem[0] = ref_mem[0];
`endif
    endfunction

    task automatic preload(input logic [12:0] a, input logic [7:0] v);
        @(negedge clk);
        pl_we = 1'b1; pl_a = a; pl_d = v;
        ref_mem[a] = v;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    // Issues one request and watches it; the start-sampling edge is edge 1
    task automatic run_op(input logic [12:0] b, input logic [7:0] c, input logic [12:0] d,
                          input bit hold, output int lat, output int ndone, output int nbusy);
        int n;
        int post;
        addr_q.delete();
        lat = 0; ndone = 0; nbusy = 0; post = 0;
        @(negedge clk);
        baseAddr = b; count = c; dstAddr = d; start = 1'b1;
        @(posedge clk);
        n = 1;
        while (n < 600 && post < 3) begin
            @(negedge clk);
            if (busy && !memWriteEn && !done) addr_q.push_back(memAddress);
            if (done) begin
                ndone++;
                if (lat == 0) lat = n;
            end else if (lat != 0 && busy) begin
                nbusy++;
            end
            if (lat != 0) post++;
            if (!hold || post >= 2) start = 1'b0;
            @(posedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (memWriteEn !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", memWriteEn); end
        checks++; if (memAddress !== 13'd0) begin failures++; $display("FAIL reset_addr got=%0d want=0", memAddress); end
        checks++; if (memWrData !== 8'd0) begin failures++; $display("FAIL reset_wrdata got=%h want=00", memWrData); end
        checks++; if (sum !== 16'd0) begin failures++; $display("FAIL reset_sum got=%h want=0000", sum); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_spec_vector;
        logic [15:0] exp;
        int lat, nd, nb;
        bit ok;
        for (int i = 0; i < 7; i++) preload(13'(1000 + i), 8'h1A);
        preload(13'd1007, 8'h0E);
        preload(13'd1008, 8'h0A);
        preload(13'd1009, 8'h01);
        preload(13'd2000, 8'hEE);
        preload(13'd2001, 8'hDD);
        exp = model_sum(13'd1000, 10);
        model_writeback(13'd2000, exp);
        run_op(13'd1000, 8'd10, 13'd2000, 1'b0, lat, nd, nb);
        checks++; if (sum !== exp) begin failures++; $display("FAIL vec_sum got=%h want=%h", sum, exp); end
        checks++; if (lat !== 10 + LAT_EXTRA) begin failures++; $display("FAIL vec_latency got=%0d want=%0d", lat, 10 + LAT_EXTRA); end
        checks++; if (nd !== 1 || nb !== 0) begin failures++; $display("FAIL vec_pulses done=%0d extra_busy=%0d want 1/0", nd, nb); end
        ok = (addr_q.size() == 10);
        for (int i = 0; i < addr_q.size() && ok; i++) ok = (addr_q[i] == 13'(1000 + i));
        checks++; if (!ok) begin failures++; $display("FAIL vec_addrs got_len=%0d want_len=10", addr_q.size()); end
        checks++; if (mem[2000] !== ref_mem[2000]) begin failures++; $display("FAIL vec_mem_lo got=%h want=%h", mem[2000], ref_mem[2000]); end
        checks++; if (mem[2001] !== ref_mem[2001]) begin failures++; $display("FAIL vec_mem_hi got=%h want=%h", mem[2001], ref_mem[2001]); end
    endtask

    task automatic test_zero_count;
        int lat, nd, nb;
        preload(13'd500, 8'h55);
        preload(13'd501, 8'h66);
        model_writeback(13'd500, 16'h0000);
        run_op(13'd42, 8'd0, 13'd500, 1'b0, lat, nd, nb);
        checks++; if (addr_q.size() != 0) begin failures++; $display("FAIL zero_reads got=%0d want=0", addr_q.size()); end
        checks++; if (lat !== LAT_EXTRA) begin failures++; $display("FAIL zero_latency got=%0d want=%0d", lat, LAT_EXTRA); end
        checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL zero_sum got=%h want=0000", sum); end
        checks++; if (mem[500] !== ref_mem[500] || mem[501] !== ref_mem[501])
            begin failures++; $display("FAIL zero_mem got=%h%h want=%h%h", mem[501], mem[500], ref_mem[501], ref_mem[500]); end
    endtask

    task automatic test_wrap;
        int lat, nd, nb;
        bit ok;
        preload(13'd8190, 8'hFF);
        preload(13'd8191, 8'hFF);
        preload(13'd0, 8'hFF);
        preload(13'd1, 8'hFF);
        model_writeback(13'd8191, 16'h03FC);
        run_op(13'd8190, 8'd4, 13'd8191, 1'b0, lat, nd, nb);
        checks++; if (sum !== 16'h03FC) begin failures++; $display("FAIL wrap_sum got=%h want=03fc", sum); end
        ok = (addr_q.size() == 4);
        if (ok) ok = (addr_q[0] == 13'd8190 && addr_q[1] == 13'd8191 && addr_q[2] == 13'd0 && addr_q[3] == 13'd1);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_addrs len=%0d want 8190,8191,0,1", addr_q.size()); end
        checks++; if (mem[8191] !== ref_mem[8191] || mem[0] !== ref_mem[0])
            begin failures++; $display("FAIL wrap_mem got=%h,%h want=%h,%h", mem[8191], mem[0], ref_mem[8191], ref_mem[0]); end
    endtask

    task automatic test_max_count;
        int lat, nd, nb;
        for (int i = 0; i < 255; i++) preload(13'(3000 + i), 8'hFF);
        preload(13'd4000, 8'h11);
        preload(13'd4001, 8'h22);
        model_writeback(13'd4000, 16'hFE01);
        run_op(13'd3000, 8'd255, 13'd4000, 1'b0, lat, nd, nb);
        checks++; if (sum !== 16'hFE01) begin failures++; $display("FAIL max_sum got=%h want=fe01", sum); end
        checks++; if (lat !== 255 + LAT_EXTRA) begin failures++; $display("FAIL max_latency got=%0d want=%0d", lat, 255 + LAT_EXTRA); end
        checks++; if (mem[4000] !== ref_mem[4000] || mem[4001] !== ref_mem[4001])
            begin failures++; $display("FAIL max_mem got=%h%h want=%h%h", mem[4001], mem[4000], ref_mem[4001], ref_mem[4000]); end
    endtask

    task automatic test_random;
        logic [12:0] b, d;
        int c, lat, nd, nb;
        logic [15:0] exp;
        bit ok;
        for (int t = 0; t < 5; t++) begin
            b = 13'($urandom_range(0, MEM_N - 1));
            d = 13'($urandom_range(0, MEM_N - 1));
            c = $urandom_range(1, 30);
            for (int i = 0; i < c; i++) preload(13'((int'(b) + i) % MEM_N), 8'($urandom));
            preload(d, 8'($urandom));
            preload(13'((int'(d) + 1) % MEM_N), 8'($urandom));
            exp = model_sum(b, c);
            model_writeback(d, exp);
            run_op(b, 8'(c), d, 1'($urandom_range(0, 1)), lat, nd, nb);
            ok = (addr_q.size() == c);
            for (int i = 0; i < addr_q.size() && ok; i++) ok = (addr_q[i] == 13'((int'(b) + i) % MEM_N));
            checks++;
            if (sum !== exp || lat !== c + LAT_EXTRA || nd !== 1 || nb !== 0 || !ok) begin
                failures++;
                $display("FAIL rand%0d sum=%h/%h lat=%0d/%0d done=%0d extra_busy=%0d addrs_ok=%0d",
                         t, sum, exp, lat, c + LAT_EXTRA, nd, nb, ok);
            end
            checks++;
            if (mem[d] !== ref_mem[d] || mem[(int'(d) + 1) % MEM_N] !== ref_mem[(int'(d) + 1) % MEM_N]) begin
                failures++;
                $display("FAIL rand%0d_mem got=%h,%h want=%h,%h", t, mem[d], mem[(int'(d) + 1) % MEM_N],
                         ref_mem[d], ref_mem[(int'(d) + 1) % MEM_N]);
            end
        end
    endtask

    task automatic test_hold_start;
        int lat, nd, nb;
        logic [15:0] exp;
        for (int i = 0; i < 6; i++) preload(13'(100 + i), 8'(i * 17 + 3));
        exp = model_sum(13'd100, 6);
        run_op(13'd100, 8'd6, 13'd200, 1'b1, lat, nd, nb);
        checks++; if (nd !== 1) begin failures++; $display("FAIL hold_done_pulses got=%0d want=1", nd); end
        checks++; if (nb !== 0 || busy !== 1'b0) begin failures++; $display("FAIL hold_restart extra_busy=%0d busy=%b want 0/0", nb, busy); end
        checks++; if (sum !== exp) begin failures++; $display("FAIL hold_sum got=%h want=%h", sum, exp); end
    endtask

    task automatic test_reset_mid;
        bit found = 1'b0;
        for (int i = 0; i < 10; i++) preload(13'(600 + i), 8'h33);
        preload(13'd700, 8'hA5);
        preload(13'd701, 8'h5A);
        @(negedge clk);
        baseAddr = 13'd600; count = 8'd10; dstAddr = 13'd700; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
`ifdef MEM_SUM_WRITEBACK_EN
            if (memWriteEn) found = 1'b1;
`else
            if (k == 3) found = 1'b1;
`endif
            if (!found) @(negedge clk);
        end
        checks++; if (!found) begin failures++; $display("FAIL rstmid_trigger got=none want=write_cycle"); end
        rst = 1'b1;
        #1;
        checks++; if (memWriteEn !== 1'b0) begin failures++; $display("FAIL rstmid_we got=%b want=0", memWriteEn); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_busy busy=%b done=%b want 0/0", busy, done); end
        checks++; if (sum !== 16'd0 || memAddress !== 13'd0) begin failures++; $display("FAIL rstmid_clear sum=%h addr=%0d want 0/0", sum, memAddress); end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (mem[700] !== 8'hA5 || mem[701] !== 8'h5A)
            begin failures++; $display("FAIL rstmid_mem got=%h,%h want=a5,5a", mem[700], mem[701]); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_spec_vector();
        test_zero_count();
        test_wrap();
        test_max_count();
        test_random();
        test_hold_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule : tb_mem_sum_engine

`default_nettype wire
